// File: rtl/sprite_overlay_if.sv
// Pixel-stream, sprite ROM and palette signals shared between the compositor
// and its surroundings (background renderer, ROM, palette, VGA output).
interface sprite_overlay_if #(
    parameter int IDX_BITS  = 2,
    parameter int ADDR_BITS = 12
);
    logic [9:0]           DrawX;
    logic [9:0]           DrawY;
    logic                 blank;
    logic [3:0]           bg_red;
    logic [3:0]           bg_green;
    logic [3:0]           bg_blue;
    logic [9:0]           pos_x;
    logic [9:0]           pos_y;
    logic                 show;
    logic [ADDR_BITS-1:0] rom_addr;
    logic [IDX_BITS-1:0]  rom_q;
    logic [IDX_BITS-1:0]  pal_index;
    logic [3:0]           pal_red;
    logic [3:0]           pal_green;
    logic [3:0]           pal_blue;
    logic [3:0]           red;
    logic [3:0]           green;
    logic [3:0]           blue;
    logic [4:0]           fade_level;
    logic                 fading;

    modport master (
        output DrawX, DrawY, blank, bg_red, bg_green, bg_blue, pos_x, pos_y, show,
        output rom_q, pal_red, pal_green, pal_blue,
        input  rom_addr, pal_index, red, green, blue, fade_level, fading
    );

    modport slave (
        input  DrawX, DrawY, blank, bg_red, bg_green, bg_blue, pos_x, pos_y, show,
        input  rom_q, pal_red, pal_green, pal_blue,
        output rom_addr, pal_index, red, green, blue, fade_level, fading
    );
endinterface

// File: rtl/sprite_overlay.sv
// Sprite compositor: scaled indexed-colour sprite alpha-blended over the
// background stream, with a frame-synchronous fade in/out.
//
//   state    | meaning
//   HIDDEN   | sprite invisible, opacity held at 0
//   FADE_IN  | opacity rising one step every FADE_FRAMES frames
//   SHOWN    | sprite fully opaque, opacity held at 16
//   FADE_OUT | opacity falling one step every FADE_FRAMES frames
module sprite_overlay #(
    parameter int SPR_W       = 80,
    parameter int SPR_H       = 45,
    parameter int IDX_BITS    = 2,
    parameter int ADDR_BITS   = 12,
    parameter int SCALE_LOG2  = 2,
    parameter int TRANSP_IDX  = 0,
    parameter int FADE_FRAMES = 2
) (
    input logic            vga_clk,
    input logic            rst_n,
    sprite_overlay_if.slave bus
);
    localparam int BOX_W = SPR_W << SCALE_LOG2;
    localparam int BOX_H = SPR_H << SCALE_LOG2;
    localparam int CNT_W = $clog2(FADE_FRAMES + 1);

    typedef enum logic [1:0] {HIDDEN, FADE_IN, SHOWN, FADE_OUT} state_t;

    state_t               state, state_n;
    logic [4:0]           level, level_n;
    logic [CNT_W-1:0]     fcnt, fcnt_n;

    logic                 origin, origin_q, tick;
    logic [9:0]           px, py, cur_px, cur_py;
    logic [10:0]          dx, dy;
    logic [9:0]           col, row;
    logic                 in_x, in_y, in_box;
    logic [ADDR_BITS-1:0] addr_n, rom_addr;
    logic                 in_box_s0, in_box_s1, blank_s0, blank_s1;
    logic [11:0]          bg_s0, bg_s1;
    logic                 texel_on;
    logic [3:0]           mix_r, mix_g, mix_b;
    logic [3:0]           red, green, blue;

    function automatic logic [3:0] blend(input logic [3:0] fg, input logic [3:0] bg,
                                         input logic [4:0] l);
        logic [8:0] sum;
        sum = 9'(fg) * 9'(l) + 9'(bg) * (9'd16 - 9'(l));
        return 4'(sum >> 4);
    endfunction

    assign origin = (bus.DrawX == 10'd0) && (bus.DrawY == 10'd0);
    assign tick   = origin && !origin_q;

    // The tick pixel already belongs to the new frame, so it uses the new position.
    assign cur_px = tick ? bus.pos_x : px;
    assign cur_py = tick ? bus.pos_y : py;

    assign dx     = {1'b0, bus.DrawX} - {1'b0, cur_px};
    assign dy     = {1'b0, bus.DrawY} - {1'b0, cur_py};
    assign in_x   = !dx[10] && (32'(dx[9:0]) < BOX_W);
    assign in_y   = !dy[10] && (32'(dy[9:0]) < BOX_H);
    assign in_box = in_x && in_y;
    assign col    = dx[9:0] >> SCALE_LOG2;
    assign row    = dy[9:0] >> SCALE_LOG2;
    assign addr_n = in_box ? ADDR_BITS'(32'(row) * SPR_W + 32'(col)) : '0;

    assign texel_on = in_box_s1 && (bus.rom_q != IDX_BITS'(TRANSP_IDX));
    assign mix_r    = blend(bus.pal_red,   bg_s1[11:8], level);
    assign mix_g    = blend(bus.pal_green, bg_s1[7:4],  level);
    assign mix_b    = blend(bus.pal_blue,  bg_s1[3:0],  level);

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            origin_q  <= 1'b0;
            px        <= '0;
            py        <= '0;
            rom_addr  <= '0;
            in_box_s0 <= 1'b0;
            in_box_s1 <= 1'b0;
            blank_s0  <= 1'b0;
            blank_s1  <= 1'b0;
            bg_s0     <= '0;
            bg_s1     <= '0;
            red       <= '0;
            green     <= '0;
            blue      <= '0;
        end else begin
            origin_q  <= origin;
            if (tick) begin
                px <= bus.pos_x;
                py <= bus.pos_y;
            end
            rom_addr  <= addr_n;
            in_box_s0 <= in_box;
            blank_s0  <= bus.blank;
            bg_s0     <= {bus.bg_red, bus.bg_green, bus.bg_blue};
            in_box_s1 <= in_box_s0;
            blank_s1  <= blank_s0;
            bg_s1     <= bg_s0;
            if (!blank_s1)
                {red, green, blue} <= '0;
            else if (texel_on)
                {red, green, blue} <= {mix_r, mix_g, mix_b};
            else
                {red, green, blue} <= bg_s1;
        end
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HIDDEN;
            level <= '0;
            fcnt  <= '0;
        end else begin
            state <= state_n;
            level <= level_n;
            fcnt  <= fcnt_n;
        end
    end

    // A show-driven state change wins over a simultaneous tick: no step, counter cleared.
    always_comb begin
        state_n = state;
        level_n = level;
        fcnt_n  = fcnt;
        case (state)
            HIDDEN: begin
                level_n = '0;
                fcnt_n  = '0;
                if (bus.show) state_n = FADE_IN;
            end
            FADE_IN: begin
                if (!bus.show) begin
                    state_n = FADE_OUT;
                    fcnt_n  = '0;
                end else if (tick) begin
                    if (fcnt == CNT_W'(FADE_FRAMES - 1)) begin
                        fcnt_n = '0;
                        if (level >= 5'd15) begin
                            level_n = 5'd16;
                            state_n = SHOWN;
                        end else begin
                            level_n = level + 5'd1;
                        end
                    end else begin
                        fcnt_n = fcnt + CNT_W'(1);
                    end
                end
            end
            SHOWN: begin
                level_n = 5'd16;
                fcnt_n  = '0;
                if (!bus.show) state_n = FADE_OUT;
            end
            FADE_OUT: begin
                if (bus.show) begin
                    state_n = FADE_IN;
                    fcnt_n  = '0;
                end else if (tick) begin
                    if (fcnt == CNT_W'(FADE_FRAMES - 1)) begin
                        fcnt_n = '0;
                        if (level <= 5'd1) begin
                            level_n = '0;
                            state_n = HIDDEN;
                        end else begin
                            level_n = level - 5'd1;
                        end
                    end else begin
                        fcnt_n = fcnt + CNT_W'(1);
                    end
                end
            end
            default: state_n = HIDDEN;
        endcase
    end

    assign bus.rom_addr   = rom_addr;
    assign bus.pal_index  = bus.rom_q;
    assign bus.red        = red;
    assign bus.green      = green;
    assign bus.blue       = blue;
    assign bus.fade_level = level;
    assign bus.fading     = (state == FADE_IN) || (state == FADE_OUT);
endmodule

// File: tb/tb_sprite_overlay.sv
// Directed + randomised bench for sprite_overlay against a behavioural model
// of placement, transparency, blending and the fade sequence.
module tb_sprite_overlay;
    localparam int SPR_W = 80;
    localparam int SPR_H = 45;
    localparam int SCALE = 4;
    localparam int FF    = 2;

    logic vga_clk = 1'b0;
    logic rst_n;
    always #5 vga_clk = ~vga_clk;

    sprite_overlay_if #(.IDX_BITS(2), .ADDR_BITS(12)) bus ();

    sprite_overlay #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .IDX_BITS(2), .ADDR_BITS(12),
        .SCALE_LOG2(2), .TRANSP_IDX(0), .FADE_FRAMES(FF)
    ) dut (
        .vga_clk(vga_clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    logic [1:0] rom   [0:4095];
    logic [3:0] pal_r [0:3];
    logic [3:0] pal_g [0:3];
    logic [3:0] pal_b [0:3];

    always @(posedge vga_clk) bus.rom_q <= rom[bus.rom_addr];
    assign bus.pal_red   = pal_r[bus.pal_index];
    assign bus.pal_green = pal_g[bus.pal_index];
    assign bus.pal_blue  = pal_b[bus.pal_index];

    int checks;
    int failures;

    // Model: opacity m_L, direction of travel m_dir (+1 toward shown, -1 toward hidden),
    // and whether it has come to rest at an end point.
    int m_L, m_dir, m_cnt, m_px, m_py;
    bit m_rest, m_prev;
    int exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_L = 0; m_dir = -1; m_rest = 1; m_cnt = 0;
        m_px = 0; m_py = 0; m_prev = 0;
        exp_q.delete();
    endtask

    task automatic model_fade(input bit s, input bit t);
        int want;
        want = s ? 1 : -1;
        if (want != m_dir) begin
            m_dir = want; m_rest = 0; m_cnt = 0;
        end else if (!m_rest && t) begin
            m_cnt++;
            if (m_cnt == FF) begin
                m_cnt = 0;
                m_L = m_L + m_dir;
                if (m_L > 16) m_L = 16;
                if (m_L < 0)  m_L = 0;
                if (m_L == 0 || m_L == 16) m_rest = 1;
            end
        end
    endtask

    task automatic model_pixel(input int x, input int y, input bit bl, input int r, input int g,
                               input int b, output int rgb, output int addr);
        int dx, dy, idx;
        bit inb;
        dx   = x - m_px;
        dy   = y - m_py;
        inb  = (dx >= 0) && (dx < SPR_W * SCALE) && (dy >= 0) && (dy < SPR_H * SCALE);
        addr = inb ? (dy / SCALE) * SPR_W + dx / SCALE : 0;
        idx  = int'(rom[addr]);
        if (!bl)
            rgb = 0;
        else if (inb && idx != 0)
            rgb = (((int'(pal_r[idx]) * m_L + r * (16 - m_L)) / 16) << 8) |
                  (((int'(pal_g[idx]) * m_L + g * (16 - m_L)) / 16) << 4) |
                   ((int'(pal_b[idx]) * m_L + b * (16 - m_L)) / 16);
        else
            rgb = (r << 8) | (g << 4) | b;
    endtask

    task automatic pix(input int x, input int y, input bit bl, input int r, input int g, input int b);
        int ergb, eaddr;
        bit t;
        bus.DrawX    = 10'(x);
        bus.DrawY    = 10'(y);
        bus.blank    = bl;
        bus.bg_red   = 4'(r);
        bus.bg_green = 4'(g);
        bus.bg_blue  = 4'(b);
        t      = (x == 0 && y == 0) && !m_prev;
        m_prev = (x == 0 && y == 0);
        if (t) begin
            m_px = int'(bus.pos_x);
            m_py = int'(bus.pos_y);
        end
        model_pixel(x, y, bl, r, g, b, ergb, eaddr);
        model_fade(bus.show, t);
        @(posedge vga_clk);
        #1;
        check("rom_addr", bus.rom_addr, eaddr);
        check("fade_level", bus.fade_level, m_L);
        check("fading", bus.fading, !m_rest);
        exp_q.push_back(ergb);
        if (exp_q.size() == 3) check("pixel", {bus.red, bus.green, bus.blue}, exp_q.pop_front());
    endtask

    task automatic filler();
        pix(1, 1, 0, 0, 0, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            pix(5, 0, 0, 0, 0, 0);
            pix(0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic rand_pix(input int n);
        for (int i = 0; i < n; i++)
            pix(int'($urandom_range(440, 60)), int'($urandom_range(260, 20)),
                $urandom_range(7, 0) != 0, int'($urandom_range(15, 0)),
                int'($urandom_range(15, 0)), int'($urandom_range(15, 0)));
    endtask

    initial begin
        checks = 0;
        failures = 0;
        for (int i = 0; i < 4096; i++) rom[i] = 2'($urandom);
        for (int i = 0; i < 4; i++) begin
            pal_r[i] = 4'($urandom);
            pal_g[i] = 4'($urandom);
            pal_b[i] = 4'($urandom);
        end
        rst_n = 1'b1;
        bus.DrawX = 10'd200; bus.DrawY = 10'd60; bus.blank = 1'b0;
        bus.bg_red = 4'd0; bus.bg_green = 4'd0; bus.bg_blue = 4'd0;
        bus.pos_x = 10'd0; bus.pos_y = 10'd0; bus.show = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge vga_clk);
        #1;
        check("reset_rgb", {bus.red, bus.green, bus.blue}, 0);
        check("reset_level", bus.fade_level, 0);
        check("reset_fading", bus.fading, 0);
        check("reset_addr", bus.rom_addr, 0);
        rst_n = 1'b1;

        // Hidden sprite: background passes straight through.
        rand_pix(100);

        bus.pos_x = 10'd100;
        bus.pos_y = 10'd50;
        bus.show  = 1'b1;
        ticks(10);
        check("fade_mid_level", bus.fade_level, 5);

        pix(99, 57, 1, 9, 10, 11);
        pix(1, 1, 1, 4, 5, 6);
        pix(103, 57, 1, 3, 3, 3);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_rgb", {bus.red, bus.green, bus.blue}, 0);
        check("async_rst_level", bus.fade_level, 0);
        check("async_rst_fading", bus.fading, 0);
        check("async_rst_addr", bus.rom_addr, 0);
        model_reset();
        repeat (3) begin
            @(posedge vga_clk);
            #1;
            check("rst_hold_level", bus.fade_level, 0);
            check("rst_hold_fading", bus.fading, 0);
        end
        rst_n = 1'b1;
        filler();
        check("fade_in_after_release", bus.fading, 1);

        ticks(31);
        check("fadein_31_level", bus.fade_level, 15);
        check("fadein_31_fading", bus.fading, 1);
        ticks(1);
        check("fadein_32_level", bus.fade_level, 16);
        check("fadein_32_fading", bus.fading, 0);

        pix(103, 57, 1, 1, 2, 3);
        check("place_addr_80", bus.rom_addr, 80);
        pix(99, 57, 1, 9, 10, 11);
        check("place_left_out", bus.rom_addr, 0);
        filler();
        filler();
        check("place_left_bg", {bus.red, bus.green, bus.blue}, 12'h9AB);
        pix(419, 57, 1, 2, 2, 2);
        check("place_right_in", bus.rom_addr, 159);
        pix(420, 57, 1, 2, 2, 2);
        check("place_right_out", bus.rom_addr, 0);
        pix(103, 229, 1, 2, 2, 2);
        check("place_bottom_in", bus.rom_addr, 3520);
        pix(103, 230, 1, 2, 2, 2);
        check("place_bottom_out", bus.rom_addr, 0);
        rand_pix(200);

        filler();
        filler();
        rom[80] = 2'd0;
        rom[81] = 2'd1;
        pal_r[1] = 4'd15; pal_g[1] = 4'd15; pal_b[1] = 4'd15;
        pix(103, 57, 1, 5, 6, 7);
        filler();
        filler();
        check("transp_bg", {bus.red, bus.green, bus.blue}, 12'h567);
        pix(103, 57, 0, 5, 6, 7);
        filler();
        filler();
        check("blank_black", {bus.red, bus.green, bus.blue}, 12'h000);
        pix(107, 57, 1, 0, 0, 0);
        filler();
        filler();
        check("blend_l16", {bus.red, bus.green, bus.blue}, 12'hFFF);

        bus.show = 1'b0;
        filler();
        ticks(16);
        check("fadeout_l8", bus.fade_level, 8);
        pix(107, 57, 1, 0, 0, 0);
        filler();
        filler();
        check("blend_l8", {bus.red, bus.green, bus.blue}, 12'h777);
        rand_pix(100);

        bus.show = 1'b1;
        filler();
        ticks(4);
        check("refade_l10", bus.fade_level, 10);
        bus.show = 1'b0;
        filler();
        check("reverse_keeps_l", bus.fade_level, 10);
        ticks(19);
        check("fadeout_19_level", bus.fade_level, 1);
        ticks(1);
        check("fadeout_20_level", bus.fade_level, 0);
        check("fadeout_20_fading", bus.fading, 0);

        pix(107, 57, 1, 3, 4, 5);
        filler();
        filler();
        check("blend_l0_bg", {bus.red, bus.green, bus.blue}, 12'h345);
        rand_pix(100);

        // Show toggling every cycle, ticks included: opacity must never move.
        for (int i = 0; i < 40; i++) begin
            bus.show = i[0];
            pix((i % 4 == 3) ? 0 : 5, 0, 0, 0, 0, 0);
        end
        check("toggle_level", bus.fade_level, 0);
        bus.show = 1'b0;
        ticks(2);

        filler();
        bus.pos_x = 10'd200;
        pix(103, 57, 1, 1, 1, 1);
        check("latch_old_pos", bus.rom_addr, 80);
        ticks(1);
        pix(203, 57, 1, 1, 1, 1);
        check("latch_new_pos", bus.rom_addr, 80);
        pix(103, 57, 1, 1, 1, 1);
        check("latch_old_gone", bus.rom_addr, 0);
        filler();
        filler();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sprite_overlay.md
# sprite_overlay

Parametrised sprite compositor for the VGA path: draws a SPR_W x SPR_H indexed-colour sprite at a runtime position with power-of-two integer scaling over a background pixel stream. Supports a transparent colour index and a frame-synchronous fade-in/fade-out state machine. Sits between the background renderer (board or screen image) and the VGA output registers. Drives an external synchronous sprite ROM and a combinational palette.

## Interface
- SPR_W, 80: sprite width in texels
- SPR_H, 45: sprite height in texels
- IDX_BITS, 2: palette index width (rom_q)
- ADDR_BITS, 12: ROM address width; must hold SPR_W*SPR_H-1
- SCALE_LOG2, 2: each texel covers 2^SCALE_LOG2 x 2^SCALE_LOG2 screen pixels
- TRANSP_IDX, 0: index treated as transparent
- FADE_FRAMES, 2: frames per fade step; must be ≥1
- vga_clk  in  1  pixel clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- DrawX, DrawY  in  10 each  current pixel coordinate
- blank  in  1  1 = active video
- bg_red, bg_green, bg_blue  in  4 each  background pixel for (DrawX, DrawY)
- pos_x, pos_y  in  10 each  sprite top-left; sampled at frame tick
- show  in  1  level request: 1 = sprite visible, 0 = hidden
- rom_addr  out  ADDR_BITS  registered ROM address
- rom_q  in  IDX_BITS  ROM data, valid one cycle after rom_addr
- pal_index  out  IDX_BITS  equals rom_q
- pal_red, pal_green, pal_blue  in  4 each  combinational palette output
- red, green, blue  out  4 each  composited pixel, registered
- fade_level  out  5  current opacity, 0..16
- fading  out  1  1 in FADE_IN or FADE_OUT

## Operation
- Frame tick: the cycle with DrawX==0 and DrawY==0 whose previous cycle did not satisfy this. Produces one pulse per frame.
- At each frame tick: pos_x and pos_y are latched into px and py. Mid-frame changes to pos_x/pos_y have no effect until the next tick.
- Box: in_box = DrawX−px in [0, SPR_W<<SCALE_LOG2) and DrawY−py in [0, SPR_H<<SCALE_LOG2). Use unsigned compare after subtraction; the compare must reject negative differences. No screen-edge wrap.
- Address: col = (DrawX−px)>>SCALE_LOG2, row = (DrawY−py)>>SCALE_LOG2, addr = row*SPR_W + col. When not in_box, rom_addr holds 0.
- Texel opacity: texel_on = in_box (delayed) AND rom_q≠TRANSP_IDX.
- Blend per channel: out = (pal*L + bg*(16−L))>>4, where L = fade_level. Intermediates are 9 bits. The result never exceeds 15.
- If texel_on=0, out = bg. If blank=0 (delayed), out = 0.
- Fade FSM, states HIDDEN, FADE_IN, SHOWN, FADE_OUT:
  - HIDDEN: L=0. Goes to FADE_IN when show=1.
  - FADE_IN: L increments by 1 each FADE_FRAMES-th frame tick. Goes to SHOWN on the tick where L reaches 16. Goes to FADE_OUT as soon as show=0, keeping the current L.
  - SHOWN: L=16. Goes to FADE_OUT when show=0.
  - FADE_OUT: L decrements by 1 each FADE_FRAMES-th frame tick. Goes to HIDDEN on the tick where L reaches 0. Goes to FADE_IN as soon as show=1, keeping the current L.
  - show is evaluated every cycle. L changes only on frame ticks.
  - The frame counter clears on every state change and on every L step.
  - A state change and a frame tick in the same cycle: the state changes, L does not step, and the counter clears.
- fading = 1 in FADE_IN or FADE_OUT.

## Timing
- Pipeline:
  - Stage 0 (posedge t): register rom_addr, in_box, blank, bg.
  - Stage 1 (t+1): rom_q valid, palette and blend computed combinationally.
  - Stage 2 (posedge t+2): red/green/blue registered.
- Total latency from DrawX/DrawY/bg/blank to red/green/blue is 2 clocks. All side signals are delayed to match.
- Reset (async assert, sync release): rom_addr=0, red/green/blue=0, state=HIDDEN, fade_level=0, fading=0, frame counter=0, px=py=0, pipeline regs cleared.
- Reset mid-fade: L returns to 0 immediately. No fade resumes after release until show is sampled.
- show toggling faster than one frame: no L change. Only the state flips.

## Test plan
- Reset: hold rst_n=0 mid-line with show=1 -> all outputs 0, fade_level=0. Release -> FADE_IN next cycle.
- Placement: SCALE_LOG2=2, SHOWN, pos=(100,50), DrawX=103, DrawY=57 -> rom_addr=1*80+0=80. DrawX=99 -> rom_addr=0 and output=bg 2 cycles later. DrawX=419 in box, DrawX=420 out.
- Transparency/blank: SHOWN, rom_q=TRANSP_IDX, bg=(5,6,7) -> out (5,6,7). Same with blank=0 -> out (0,0,0).
- Blend: L=8, pal=(15,15,15), bg=(0,0,0) -> (7,7,7). L=16 -> (15,15,15). L=0 -> bg.
- Fade sequence: FADE_FRAMES=2, show=1 from HIDDEN -> L=16 and SHOWN after 32 frame ticks. show=0 at L=10 during FADE_IN -> FADE_OUT, L reaches 0 after 20 more ticks.
- Position latch: change pos_x mid-frame -> rendering unchanged until the next frame tick, then moves.
